// File: rtl/mux_nx1_rr.sv
// Registered N:1 mux with manual select or round-robin auto-select; latency 1 clk, no backpressure.
// Optional burst-hold lock on the current round-robin grant when MUX_RR_LOCK_EN is defined.
module mux_nx1_rr #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH*WIDTH-1:0] In_data,
    input  logic [NUM_CH-1:0]       In_valid,
    input  logic [SEL_W-1:0]        Select_in,
    input  logic                    Mode_in,
`ifdef MUX_RR_LOCK_EN
    input  logic                    Lock_in,
`endif
    output logic [WIDTH-1:0]        Y_out,
    output logic                    Y_valid,
    output logic [SEL_W-1:0]        Y_sel
);

    localparam int DEPTH = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);

    // Pad channels up to the full index space so out-of-range selects read as invalid.
    logic [DEPTH-1:0] valid_pad;
    logic [WIDTH-1:0] ch_data [DEPTH];

    always_comb begin
        valid_pad = '0;
        valid_pad[NUM_CH-1:0] = In_valid;
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_ch
        if (k < NUM_CH) begin : g_real
            assign ch_data[k] = In_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign ch_data[k] = '0;
        end
    end

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] rr_grant;
    logic [SEL_W-1:0] cand;
    logic             rr_found;
    logic             lock_hold;

    // Walk forward from the last grant, wrapping at NUM_CH-1; first valid channel wins.
    always_comb begin
        cand     = rr_ptr;
        rr_found = 1'b0;
        rr_grant = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (cand == LAST) ? '0 : cand + 1'b1;
            if (!rr_found && valid_pad[cand]) begin
                rr_found = 1'b1;
                rr_grant = cand;
            end
        end
    end

`ifdef MUX_RR_LOCK_EN
    assign lock_hold = Lock_in & Y_valid & valid_pad[Y_sel];
`else
    assign lock_hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            Y_out   <= '0;
            Y_valid <= 1'b0;
            Y_sel   <= '0;
            rr_ptr  <= LAST;
        end else if (Mode_in) begin
            if (lock_hold) begin
                Y_out   <= ch_data[Y_sel];
                Y_valid <= 1'b1;
            end else if (rr_found) begin
                Y_out   <= ch_data[rr_grant];
                Y_valid <= 1'b1;
                Y_sel   <= rr_grant;
                rr_ptr  <= rr_grant;
            end else begin
                Y_valid <= 1'b0;
            end
        end else begin
            if (valid_pad[Select_in]) begin
                Y_out   <= ch_data[Select_in];
                Y_valid <= 1'b1;
                Y_sel   <= Select_in;
            end else begin
                Y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Directed bench for mux_nx1_rr with default parameters (4 channels, 8-bit data).
// Lock scenario is compiled in only when MUX_RR_LOCK_EN is defined.
module tb_mux_nx1_rr;

    logic        clk;
    logic        reset;
    logic [31:0] In_data;
    logic [3:0]  In_valid;
    logic [1:0]  Select_in;
    logic        Mode_in;
`ifdef MUX_RR_LOCK_EN
    logic        Lock_in;
`endif
    logic [7:0]  Y_out;
    logic        Y_valid;
    logic [1:0]  Y_sel;

    int checks   = 0;
    int failures = 0;

    mux_nx1_rr #(.NUM_CH(4), .WIDTH(8), .SEL_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .In_data   (In_data),
        .In_valid  (In_valid),
        .Select_in (Select_in),
        .Mode_in   (Mode_in),
`ifdef MUX_RR_LOCK_EN
        .Lock_in   (Lock_in),
`endif
        .Y_out     (Y_out),
        .Y_valid   (Y_valid),
        .Y_sel     (Y_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    function automatic logic [7:0] dat(input int ch);
        logic [7:0] t [4];
        t[0] = 8'h11; t[1] = 8'h22; t[2] = 8'h33; t[3] = 8'h44;
        return t[ch];
    endfunction

    task automatic test_reset();
        Mode_in = 1'b1; In_valid = 4'hF; Select_in = 2'd0;
        do_reset();
        checks++; if (Y_out !== 8'h00) begin failures++; $display("FAIL reset_y_out got=%h exp=00", Y_out); end
        checks++; if (Y_valid !== 1'b0) begin failures++; $display("FAIL reset_y_valid got=%b exp=0", Y_valid); end
        checks++; if (Y_sel !== 2'd0) begin failures++; $display("FAIL reset_y_sel got=%0d exp=0", Y_sel); end
        step();
        checks++; if (Y_sel !== 2'd0 || Y_valid !== 1'b1 || Y_out !== 8'h11) begin
            failures++; $display("FAIL reset_first_grant got sel=%0d vld=%b out=%h exp sel=0 vld=1 out=11", Y_sel, Y_valid, Y_out);
        end
    endtask

    task automatic test_manual();
        Mode_in = 1'b0; In_valid = 4'hF;
        for (int s = 0; s < 4; s++) begin
            Select_in = 2'(s);
            step();
            checks++; if (Y_out !== dat(s) || Y_valid !== 1'b1 || Y_sel !== 2'(s)) begin
                failures++; $display("FAIL manual_sel%0d got out=%h vld=%b sel=%0d exp out=%h vld=1 sel=%0d", s, Y_out, Y_valid, Y_sel, dat(s), s);
            end
        end
        In_valid = 4'b0111; Select_in = 2'd3;
        step();
        checks++; if (Y_valid !== 1'b0) begin failures++; $display("FAIL manual_invalid_vld got=%b exp=0", Y_valid); end
        checks++; if (Y_out !== 8'h44 || Y_sel !== 2'd3) begin
            failures++; $display("FAIL manual_invalid_hold got out=%h sel=%0d exp out=44 sel=3", Y_out, Y_sel);
        end
    endtask

    task automatic test_rr_fair();
        Mode_in = 1'b1; In_valid = 4'hF;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (Y_sel !== 2'(i % 4) || Y_out !== dat(i % 4) || Y_valid !== 1'b1) begin
                failures++; $display("FAIL rr_fair_%0d got sel=%0d out=%h vld=%b exp sel=%0d out=%h vld=1", i, Y_sel, Y_out, Y_valid, i % 4, dat(i % 4));
            end
        end
        // Last grant was ch3, so the search restarts at ch0 and finds ch1 first.
        In_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (Y_sel !== ((i % 2 == 0) ? 2'd1 : 2'd3) || Y_valid !== 1'b1) begin
                failures++; $display("FAIL rr_alt_%0d got sel=%0d vld=%b exp sel=%0d vld=1", i, Y_sel, Y_valid, (i % 2 == 0) ? 1 : 3);
            end
        end
    endtask

    task automatic test_wrap_idle();
        Mode_in = 1'b1; In_valid = 4'b0100;
        step();
        checks++; if (Y_sel !== 2'd2 || Y_out !== 8'h33) begin
            failures++; $display("FAIL wrap_grant2 got sel=%0d out=%h exp sel=2 out=33", Y_sel, Y_out);
        end
        In_valid = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (Y_valid !== 1'b0 || Y_sel !== 2'd2 || Y_out !== 8'h33) begin
                failures++; $display("FAIL idle_%0d got vld=%b sel=%0d out=%h exp vld=0 sel=2 out=33", i, Y_valid, Y_sel, Y_out);
            end
        end
        In_valid = 4'b0011;
        step();
        checks++; if (Y_sel !== 2'd0 || Y_valid !== 1'b1) begin
            failures++; $display("FAIL wrap_to0 got sel=%0d vld=%b exp sel=0 vld=1", Y_sel, Y_valid);
        end
        step();
        checks++; if (Y_sel !== 2'd1 || Y_valid !== 1'b1) begin
            failures++; $display("FAIL wrap_then1 got sel=%0d vld=%b exp sel=1 vld=1", Y_sel, Y_valid);
        end
    endtask

    task automatic test_single();
        Mode_in = 1'b1; In_valid = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (Y_sel !== 2'd0 || Y_valid !== 1'b1 || Y_out !== 8'h11) begin
                failures++; $display("FAIL single_%0d got sel=%0d vld=%b out=%h exp sel=0 vld=1 out=11", i, Y_sel, Y_valid, Y_out);
            end
        end
        // Re-establish the ch1 grant for the mode-switch scenario.
        In_valid = 4'b0010;
        step();
        checks++; if (Y_sel !== 2'd1) begin failures++; $display("FAIL single_to1 got sel=%0d exp=1", Y_sel); end
    endtask

    task automatic test_mode_switch();
        In_valid = 4'hF; Mode_in = 1'b0; Select_in = 2'd3;
        step();
        checks++; if (Y_sel !== 2'd3 || Y_out !== 8'h44 || Y_valid !== 1'b1) begin
            failures++; $display("FAIL mode_manual got sel=%0d out=%h vld=%b exp sel=3 out=44 vld=1", Y_sel, Y_out, Y_valid);
        end
        Mode_in = 1'b1;
        step();
        checks++; if (Y_sel !== 2'd2 || Y_out !== 8'h33) begin
            failures++; $display("FAIL mode_back_rr got sel=%0d out=%h exp sel=2 out=33", Y_sel, Y_out);
        end
        step();
        checks++; if (Y_sel !== 2'd3) begin failures++; $display("FAIL mode_rr_next got sel=%0d exp=3", Y_sel); end
        reset = 1'b0;
        step();
        checks++; if (Y_out !== 8'h00 || Y_valid !== 1'b0 || Y_sel !== 2'd0) begin
            failures++; $display("FAIL midrun_reset got out=%h vld=%b sel=%0d exp out=00 vld=0 sel=0", Y_out, Y_valid, Y_sel);
        end
        reset = 1'b1;
        step();
        checks++; if (Y_sel !== 2'd0 || Y_valid !== 1'b1 || Y_out !== 8'h11) begin
            failures++; $display("FAIL midrun_restart got sel=%0d vld=%b out=%h exp sel=0 vld=1 out=11", Y_sel, Y_valid, Y_out);
        end
    endtask

`ifdef MUX_RR_LOCK_EN
    task automatic test_lock();
        Mode_in = 1'b1; In_valid = 4'hF; Lock_in = 1'b0;
        do_reset();
        step();
        step();
        checks++; if (Y_sel !== 2'd1) begin failures++; $display("FAIL lock_pre got sel=%0d exp=1", Y_sel); end
        Lock_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (Y_sel !== 2'd1 || Y_valid !== 1'b1 || Y_out !== 8'h22) begin
                failures++; $display("FAIL lock_hold_%0d got sel=%0d vld=%b out=%h exp sel=1 vld=1 out=22", i, Y_sel, Y_valid, Y_out);
            end
        end
        In_valid = 4'b1101;
        step();
        checks++; if (Y_sel !== 2'd2 || Y_valid !== 1'b1) begin
            failures++; $display("FAIL lock_drop got sel=%0d vld=%b exp sel=2 vld=1", Y_sel, Y_valid);
        end
        step();
        checks++; if (Y_sel !== 2'd2) begin failures++; $display("FAIL lock_rehold got sel=%0d exp=2", Y_sel); end
        Lock_in = 1'b0;
        step();
        checks++; if (Y_sel !== 2'd3) begin failures++; $display("FAIL lock_release got sel=%0d exp=3", Y_sel); end
    endtask
`endif

    initial begin
        reset     = 1'b0;
        In_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        In_valid  = 4'h0;
        Select_in = 2'd0;
        Mode_in   = 1'b0;
`ifdef MUX_RR_LOCK_EN
        Lock_in   = 1'b0;
`endif
        #1;
        test_reset();
        test_manual();
        test_rr_fair();
        test_wrap_idle();
        test_single();
        test_mode_switch();
`ifdef MUX_RR_LOCK_EN
        test_lock();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
